// File: rtl/step_counter.sv
// Load/step counter used to sequence the exponent-align and normalise shift loops of an FP adder.
// A run loads a start value and steps toward a limit; done pulses once when the limit is reached.
module step_counter #(
  parameter int WIDTH       = 8,
  parameter int STEP_W      = 4,
  parameter int SAT         = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WIDTH-1:0]  i_n,
  input  logic [WIDTH-1:0]  i_lim,
  input  logic              i_dir,
  input  logic              i_ld,
  input  logic              i_cen,
  input  logic [STEP_W-1:0] i_step,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_complete,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_wrapped,
  output logic [1:0]        o_state
);

  // Control inputs are level qualifiers sampled at every posedge (no ready):
  // priority is i_rst > i_ld > i_cen, and i_step is used live each enabled cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_n_q;
  logic [WIDTH-1:0] r_lim_q;
  logic             r_dir_q;
  logic             r_done;
  logic             r_wrapped;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrapped_nxt;
  logic             w_done_nxt;
  logic             w_hit;
  logic             w_load;

  logic [WIDTH-1:0] w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_upd;
  logic             w_term_upd;
  logic             w_term_nq;
  logic             w_term_ld;
  logic             w_term_cur;

  assign w_step_ext = {{(WIDTH-STEP_W){1'b0}}, i_step};
  assign w_sum      = r_dir_q ? ({1'b0, r_count} + {1'b0, w_step_ext})
                              : ({1'b0, r_count} - {1'b0, w_step_ext});
  // Bit WIDTH is the carry when counting up and the borrow when counting down.
  assign w_ovf      = w_sum[WIDTH];

  always_comb begin
    w_upd = w_sum[WIDTH-1:0];
    if (w_ovf && (SAT != 0)) begin
      w_upd = r_dir_q ? ALL_ONES : '0;
    end
  end

  assign w_term_upd = r_dir_q ? (w_upd >= r_lim_q)   : (w_upd <= r_lim_q);
  assign w_term_nq  = r_dir_q ? (r_n_q >= r_lim_q)   : (r_n_q <= r_lim_q);
  assign w_term_ld  = i_dir   ? (i_n >= i_lim)       : (i_n <= i_lim);
  assign w_term_cur = r_dir_q ? (r_count >= r_lim_q) : (r_count <= r_lim_q);

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_wrapped_nxt = r_wrapped;
    w_hit         = 1'b0;
    w_load        = 1'b0;
    if (i_ld) begin
      w_load        = 1'b1;
      w_count_nxt   = i_n;
      w_wrapped_nxt = 1'b0;
      if (w_term_ld) begin
        w_state_nxt = S_DONE;
        w_hit       = 1'b1;
      end else begin
        w_state_nxt = S_RUN;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_cen && (i_step != '0)) begin
            w_count_nxt = w_upd;
            if (w_ovf && (SAT == 0)) begin
              w_wrapped_nxt = 1'b1;
            end
            if (w_term_upd) begin
              w_state_nxt = S_DONE;
              w_hit       = 1'b1;
            end
          end
        end
        S_DONE: begin
          if ((AUTO_RELOAD != 0) && i_cen) begin
            w_count_nxt   = r_n_q;
            w_wrapped_nxt = 1'b0;
            if (w_term_nq) begin
              w_hit = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
            end
          end
        end
        default: ;
      endcase
    end
    // Back-to-back terminal events (e.g. repeated reloads of a terminal start) pulse at most every other cycle.
    w_done_nxt = w_hit & ~r_done;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_n_q     <= '0;
      r_lim_q   <= '0;
      r_dir_q   <= 1'b0;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_done    <= w_done_nxt;
      r_wrapped <= w_wrapped_nxt;
      if (w_load) begin
        r_n_q   <= i_n;
        r_lim_q <= i_lim;
        r_dir_q <= i_dir;
      end
    end
  end

  assign o_count    = r_count;
  assign o_complete = w_term_cur;
  assign o_done     = r_done;
  assign o_busy     = (r_state == S_RUN);
  assign o_wrapped  = r_wrapped;
  assign o_state    = r_state;

endmodule
